// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage RV64 core: opcodes, ALU op classes and the
// decoder control bundle carried down the pipeline.
package core_pkg;

  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_SD  = 7'b0100011;
  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Field order matches the decoder output bundle, MSB first.
  typedef struct packed {
    logic       branch;
    logic       memRead;
    logic       memToReg;
    logic [1:0] aluOp;
    logic       memWrite;
    logic       aluSrc;
    logic       regWrite;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection between the instruction in ID and a load in EX.
// A branch flush suppresses the stall since the ID instruction is wrong-path.
module load_use_detect (
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_alu_src,
  input  logic       id_mem_write,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       flush,
  output logic       hazard,
  output logic       stall
);

  logic use_rs2;
  logic rs1_match;
  logic rs2_match;

  // Stores read rs2 as data even though aluSrc selects the immediate.
  assign use_rs2   = ~id_alu_src | id_mem_write;
  assign rs1_match = (ex_rd == id_rs1);
  assign rs2_match = use_rs2 & (ex_rd == id_rs2);

  assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                  (rs1_match | rs2_match);
  assign stall  = hazard & ~flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and a
// saturating stall-cycle counter for performance debug.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  input  logic             id_branch,
  input  logic             id_memRead,
  input  logic             id_memToReg,
  input  logic             id_memWrite,
  input  logic             id_aluSrc,
  input  logic             id_regWrite,
  input  logic [1:0]       id_aluOp,
  input  logic             flush,
  output logic             stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic             ex_branch,
  output logic             ex_memRead,
  output logic             ex_memToReg,
  output logic             ex_memWrite,
  output logic             ex_aluSrc,
  output logic             ex_regWrite,
  output logic [1:0]       ex_aluOp,
  output logic [CNT_W-1:0] stall_count
);

  ctrl_t             id_ctrl;
  logic              hazard;

  logic              ex_valid_d,    ex_valid_q;
  logic [XLEN-1:0]   ex_pc_d,       ex_pc_q;
  logic [XLEN-1:0]   ex_rs1_data_d, ex_rs1_data_q;
  logic [XLEN-1:0]   ex_rs2_data_d, ex_rs2_data_q;
  logic [XLEN-1:0]   ex_imm_d,      ex_imm_q;
  logic [4:0]        ex_rs1_d,      ex_rs1_q;
  logic [4:0]        ex_rs2_d,      ex_rs2_q;
  logic [4:0]        ex_rd_d,       ex_rd_q;
  logic [2:0]        ex_funct3_d,   ex_funct3_q;
  logic              ex_funct7b5_d, ex_funct7b5_q;
  ctrl_t             ex_ctrl_d,     ex_ctrl_q;
  logic [CNT_W-1:0]  stall_count_d, stall_count_q;

  assign id_ctrl = '{branch:   id_branch,
                     memRead:  id_memRead,
                     memToReg: id_memToReg,
                     aluOp:    id_aluOp,
                     memWrite: id_memWrite,
                     aluSrc:   id_aluSrc,
                     regWrite: id_regWrite};

  load_use_detect u_load_use_detect (
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_alu_src   (id_aluSrc),
    .id_mem_write (id_memWrite),
    .ex_valid     (ex_valid_q),
    .ex_mem_read  (ex_ctrl_q.memRead),
    .ex_rd        (ex_rd_q),
    .flush        (flush),
    .hazard       (hazard),
    .stall        (stall)
  );

  always_comb begin
    ex_valid_d    = 1'b0;
    ex_pc_d       = '0;
    ex_rs1_data_d = '0;
    ex_rs2_data_d = '0;
    ex_imm_d      = '0;
    ex_rs1_d      = '0;
    ex_rs2_d      = '0;
    ex_rd_d       = '0;
    ex_funct3_d   = '0;
    ex_funct7b5_d = 1'b0;
    ex_ctrl_d     = CTRL_NOP;
    // Flush and hazard both leave the all-zero bubble above.
    if (!flush && !hazard) begin
      ex_valid_d    = id_valid;
      ex_pc_d       = id_pc;
      ex_rs1_data_d = id_rs1_data;
      ex_rs2_data_d = id_rs2_data;
      ex_imm_d      = id_imm;
      ex_rs1_d      = id_rs1;
      ex_rs2_d      = id_rs2;
      ex_rd_d       = id_rd;
      ex_funct3_d   = id_funct3;
      ex_funct7b5_d = id_funct7b5;
      ex_ctrl_d     = id_valid ? id_ctrl : CTRL_NOP;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_data_q <= '0;
      ex_rs2_data_q <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_funct3_q   <= '0;
      ex_funct7b5_q <= 1'b0;
      ex_ctrl_q     <= CTRL_NOP;
      stall_count_q <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_data_q <= ex_rs1_data_d;
      ex_rs2_data_q <= ex_rs2_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7b5_q <= ex_funct7b5_d;
      ex_ctrl_q     <= ex_ctrl_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_pc       = ex_pc_q;
  assign ex_rs1_data = ex_rs1_data_q;
  assign ex_rs2_data = ex_rs2_data_q;
  assign ex_imm      = ex_imm_q;
  assign ex_rs1      = ex_rs1_q;
  assign ex_rs2      = ex_rs2_q;
  assign ex_rd       = ex_rd_q;
  assign ex_funct3   = ex_funct3_q;
  assign ex_funct7b5 = ex_funct7b5_q;
  assign ex_branch   = ex_ctrl_q.branch;
  assign ex_memRead  = ex_ctrl_q.memRead;
  assign ex_memToReg = ex_ctrl_q.memToReg;
  assign ex_memWrite = ex_ctrl_q.memWrite;
  assign ex_aluSrc   = ex_ctrl_q.aluSrc;
  assign ex_regWrite = ex_ctrl_q.regWrite;
  assign ex_aluOp    = ex_ctrl_q.aluOp;
  assign stall_count = stall_count_q;

endmodule
